// File: rtl/al_clk_pkg.sv
// Shared types and range constants for the alarm clock blocks:
// BCD HH:MM time, key-entry FSM states and the legal digit ranges.
package al_clk_pkg;

  typedef struct packed {
    logic [3:0] ms_hour;
    logic [3:0] ls_hour;
    logic [3:0] ms_min;
    logic [3:0] ls_min;
  } bcd_time_t;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_ENTRY = 1'b1
  } entry_state_e;

  localparam logic [3:0] MAX_MS_HOUR       = 4'd2;
  localparam logic [3:0] MAX_LS_HOUR_AT_20 = 4'd3;
  localparam logic [3:0] MAX_MS_MIN        = 4'd5;
  localparam logic [3:0] KEY_MAX_DIGIT     = 4'd9;

  function automatic logic is_digit(input logic [3:0] code);
    return code <= KEY_MAX_DIGIT;
  endfunction

endpackage

// File: rtl/al_clk_key_entry_if.sv
// Keypad/button inputs and commit/display outputs of the key entry buffer.
// The key entry block is the slave; whoever drives the keypad is the master.
interface al_clk_key_entry_if;

  logic [3:0]  key;
  logic        key_valid;
  logic        time_button;
  logic        alarm_button;
  logic        one_second;
  logic [15:0] key_buffer;
  logic        entry_active;
  logic [15:0] time_out;
  logic        load_new_time;
  logic        load_new_alarm;
  logic        entry_error;

  modport master (
    output key, key_valid, time_button, alarm_button, one_second,
    input  key_buffer, entry_active, time_out,
    input  load_new_time, load_new_alarm, entry_error
  );

  modport slave (
    input  key, key_valid, time_button, alarm_button, one_second,
    output key_buffer, entry_active, time_out,
    output load_new_time, load_new_alarm, entry_error
  );

endinterface

// File: rtl/al_clk_time_valid.sv
// Combinational range check of a BCD HH:MM value (00:00 .. 23:59).
// Shared with the alarm register.
module al_clk_time_valid
  import al_clk_pkg::*;
(
  input  bcd_time_t value,
  output logic      valid
);

  logic digits_ok;
  logic hours_ok;
  logic mins_ok;

  always_comb begin
    digits_ok = (value.ms_hour <= KEY_MAX_DIGIT) && (value.ls_hour <= KEY_MAX_DIGIT) &&
                (value.ms_min  <= KEY_MAX_DIGIT) && (value.ls_min  <= KEY_MAX_DIGIT);
    // 20..23 is the only decade where ls_hour is restricted.
    hours_ok  = (value.ms_hour <= MAX_MS_HOUR) &&
                !((value.ms_hour == MAX_MS_HOUR) && (value.ls_hour > MAX_LS_HOUR_AT_20));
    mins_ok   = value.ms_min <= MAX_MS_MIN;
    valid     = digits_ok && hours_ok && mins_ok;
  end

endmodule

// File: rtl/al_clk_key_entry.sv
// Keypad entry buffer: shifts BCD digits into an HH:MM buffer, validates it on
// TIME/ALARM and emits a one-cycle load strobe; abandons idle entries.
module al_clk_key_entry
  import al_clk_pkg::*;
#(
  parameter int unsigned TIMEOUT_SECONDS = 10
) (
  input logic               clk256,
  input logic               reset_n,
  al_clk_key_entry_if.slave bus
);

  // The idle-second counter is 4 bits, so TIMEOUT_SECONDS must be 1..15.
  localparam logic [3:0] TIMEOUT_LIMIT = 4'(TIMEOUT_SECONDS);

  entry_state_e state_q, state_d;
  bcd_time_t    key_buffer_q, key_buffer_d;
  bcd_time_t    time_out_q, time_out_d;
  logic [2:0]   digit_cnt_q, digit_cnt_d;
  logic [3:0]   idle_secs_q, idle_secs_d;
  logic         load_time_q, load_time_d;
  logic         load_alarm_q, load_alarm_d;
  logic         entry_error_q, entry_error_d;

  logic digit_in;
  logic commit;
  logic buffer_valid;

  al_clk_time_valid u_time_valid (
    .value (key_buffer_q),
    .valid (buffer_valid)
  );

  assign digit_in = bus.key_valid && is_digit(bus.key);
  assign commit   = bus.time_button || bus.alarm_button;

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_d       = state_q;
    key_buffer_d  = key_buffer_q;
    time_out_d    = time_out_q;
    digit_cnt_d   = digit_cnt_q;
    idle_secs_d   = idle_secs_q;
    load_time_d   = 1'b0;
    load_alarm_d  = 1'b0;
    entry_error_d = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (digit_in) begin
          key_buffer_d = bcd_time_t'({12'h000, bus.key});
          digit_cnt_d  = 3'd1;
          idle_secs_d  = 4'd0;
          state_d      = ST_ENTRY;
        end
      end

      ST_ENTRY: begin
        if (commit) begin
          // A button beats a simultaneous digit; TIME beats ALARM.
          if (buffer_valid) begin
            time_out_d   = key_buffer_q;
            load_time_d  = bus.time_button;
            load_alarm_d = !bus.time_button;
          end else begin
            entry_error_d = 1'b1;
          end
          key_buffer_d = '0;
          digit_cnt_d  = 3'd0;
          idle_secs_d  = 4'd0;
          state_d      = ST_IDLE;
        end else if (digit_in) begin
          key_buffer_d = bcd_time_t'({key_buffer_q[11:0], bus.key});
          digit_cnt_d  = (digit_cnt_q == 3'd4) ? digit_cnt_q : digit_cnt_q + 3'd1;
          idle_secs_d  = 4'd0;
        end else if (bus.one_second) begin
          if (idle_secs_q + 4'd1 == TIMEOUT_LIMIT) begin
            key_buffer_d = '0;
            digit_cnt_d  = 3'd0;
            idle_secs_d  = 4'd0;
            state_d      = ST_IDLE;
          end else begin
            idle_secs_d  = idle_secs_q + 4'd1;
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: state updates use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk256 or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= ST_IDLE;
      key_buffer_q  <= '0;
      time_out_q    <= '0;
      digit_cnt_q   <= 3'd0;
      idle_secs_q   <= 4'd0;
      load_time_q   <= 1'b0;
      load_alarm_q  <= 1'b0;
      entry_error_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      key_buffer_q  <= key_buffer_d;
      time_out_q    <= time_out_d;
      digit_cnt_q   <= digit_cnt_d;
      idle_secs_q   <= idle_secs_d;
      load_time_q   <= load_time_d;
      load_alarm_q  <= load_alarm_d;
      entry_error_q <= entry_error_d;
    end
  end

  assign bus.key_buffer     = key_buffer_q;
  assign bus.entry_active   = (state_q == ST_ENTRY);
  assign bus.time_out       = time_out_q;
  assign bus.load_new_time  = load_time_q;
  assign bus.load_new_alarm = load_alarm_q;
  assign bus.entry_error    = entry_error_q;

endmodule

// File: tb/tb_al_clk_key_entry.sv
// Directed bench for al_clk_key_entry: stimulus pushes expected commits into a
// scoreboard queue, a negedge monitor pops and compares every strobe.
module tb_al_clk_key_entry;

  typedef struct packed {
    logic [2:0]  strobes;  // {entry_error, load_new_alarm, load_new_time}
    logic [15:0] value;
  } commit_t;

  localparam logic [2:0] EXP_TIME  = 3'b001;
  localparam logic [2:0] EXP_ALARM = 3'b010;
  localparam logic [2:0] EXP_ERROR = 3'b100;

  logic clk256  = 1'b0;
  logic reset_n = 1'b0;
  int   n_checks = 0;
  int   n_fail   = 0;
  commit_t exp_q[$];

  al_clk_key_entry_if bus_if ();

  al_clk_key_entry #(.TIMEOUT_SECONDS(10)) dut (
    .clk256  (clk256),
    .reset_n (reset_n),
    .bus     (bus_if)
  );

  always #5 clk256 = ~clk256;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic [3:0] k, input logic kv, input logic tb,
                       input logic ab, input logic sec);
    @(posedge clk256);
    #1;
    bus_if.key          = k;
    bus_if.key_valid    = kv;
    bus_if.time_button  = tb;
    bus_if.alarm_button = ab;
    bus_if.one_second   = sec;
    @(posedge clk256);
    #1;
    bus_if.key_valid    = 1'b0;
    bus_if.time_button  = 1'b0;
    bus_if.alarm_button = 1'b0;
    bus_if.one_second   = 1'b0;
  endtask

  task automatic press(input logic [3:0] k);
    drive(k, 1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic enter4(input logic [15:0] digits);
    for (int i = 3; i >= 0; i--) press(digits[i*4 +: 4]);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) drive(4'd0, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic expect_commit(input logic [2:0] kind, input logic [15:0] value);
    commit_t c;
    c.strobes = kind;
    c.value   = value;
    exp_q.push_back(c);
  endtask

  // Monitor: every cycle with a strobe must match the oldest expected commit.
  always @(negedge clk256) begin
    logic [2:0] seen;
    commit_t    c;
    seen = {bus_if.entry_error, bus_if.load_new_alarm, bus_if.load_new_time};
    if (reset_n && seen != 3'b000) begin
      if (exp_q.size() == 0) begin
        check("unexpected_strobe", {29'd0, seen}, 32'd0);
      end else begin
        c = exp_q.pop_front();
        check("commit_strobes", {29'd0, seen}, {29'd0, c.strobes});
        check("commit_time_out", {16'd0, bus_if.time_out}, {16'd0, c.value});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus_if.key          = 4'd0;
    bus_if.key_valid    = 1'b0;
    bus_if.time_button  = 1'b0;
    bus_if.alarm_button = 1'b0;
    bus_if.one_second   = 1'b0;
    repeat (3) @(posedge clk256);
    #1;
    check("reset_key_buffer", {16'd0, bus_if.key_buffer}, 32'h0);
    check("reset_time_out", {16'd0, bus_if.time_out}, 32'h0);
    check("reset_entry_active", {31'd0, bus_if.entry_active}, 32'd0);
    check("reset_strobes", {29'd0, bus_if.entry_error, bus_if.load_new_alarm,
                            bus_if.load_new_time}, 32'd0);
    reset_n = 1'b1;

    // Buttons in IDLE are ignored (monitor flags any strobe).
    drive(4'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    drive(4'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    check("idle_button_active", {31'd0, bus_if.entry_active}, 32'd0);

    // 1,2,3,4 + TIME
    press(4'd1);
    check("short_entry_1", {16'd0, bus_if.key_buffer}, 32'h0001);
    check("entry_active_rise", {31'd0, bus_if.entry_active}, 32'd1);
    press(4'd2); press(4'd3); press(4'd4);
    check("buffer_1234", {16'd0, bus_if.key_buffer}, 32'h1234);
    expect_commit(EXP_TIME, 16'h1234);
    drive(4'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    check("entry_active_fall", {31'd0, bus_if.entry_active}, 32'd0);
    check("buffer_clear_commit", {16'd0, bus_if.key_buffer}, 32'h0);

    // 0,6,3,0 + ALARM
    enter4(16'h0630);
    expect_commit(EXP_ALARM, 16'h0630);
    drive(4'd0, 1'b0, 1'b0, 1'b1, 1'b0);

    // Invalid entries keep time_out
    enter4(16'h2400);
    expect_commit(EXP_ERROR, 16'h0630);
    drive(4'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    enter4(16'h1260);
    expect_commit(EXP_ERROR, 16'h0630);
    drive(4'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    check("time_out_kept", {16'd0, bus_if.time_out}, 32'h0630);

    // Upper boundary 23:59 is legal
    enter4(16'h2359);
    expect_commit(EXP_ALARM, 16'h2359);
    drive(4'd0, 1'b0, 1'b0, 1'b1, 1'b0);

    // Overflow digits and ignored key code
    enter4(16'h1234);
    press(4'd5);
    check("buffer_shift_out", {16'd0, bus_if.key_buffer}, 32'h2345);
    press(4'd12);
    check("buffer_key12", {16'd0, bus_if.key_buffer}, 32'h2345);
    expect_commit(EXP_TIME, 16'h2345);
    drive(4'd0, 1'b0, 1'b1, 1'b0, 1'b0);

    // Timeout after 10 idle ticks
    press(4'd7);
    ticks(9);
    check("tick9_still_entry", {31'd0, bus_if.entry_active}, 32'd1);
    ticks(1);
    check("timeout_idle", {31'd0, bus_if.entry_active}, 32'd0);
    check("timeout_buffer", {16'd0, bus_if.key_buffer}, 32'h0);

    // Digit on the 9th tick wins and restarts the count
    press(4'd7);
    ticks(8);
    drive(4'd7, 1'b1, 1'b0, 1'b0, 1'b1);
    ticks(1);
    check("restart_still_entry", {31'd0, bus_if.entry_active}, 32'd1);
    check("restart_buffer", {16'd0, bus_if.key_buffer}, 32'h0077);
    ticks(8);
    check("restart_tick9", {31'd0, bus_if.entry_active}, 32'd1);
    ticks(1);
    check("restart_timeout", {31'd0, bus_if.entry_active}, 32'd0);

    // Both buttons plus a digit: only load_new_time with 0005
    press(4'd5);
    expect_commit(EXP_TIME, 16'h0005);
    drive(4'd9, 1'b1, 1'b1, 1'b1, 1'b0);
    check("combo_time_out", {16'd0, bus_if.time_out}, 32'h0005);
    check("combo_buffer", {16'd0, bus_if.key_buffer}, 32'h0);

    // Asynchronous reset mid-entry
    press(4'd5);
    check("pre_reset_active", {31'd0, bus_if.entry_active}, 32'd1);
    #3 reset_n = 1'b0;
    #1;
    check("async_rst_buffer", {16'd0, bus_if.key_buffer}, 32'h0);
    check("async_rst_time_out", {16'd0, bus_if.time_out}, 32'h0);
    check("async_rst_active", {31'd0, bus_if.entry_active}, 32'd0);
    check("async_rst_strobes", {29'd0, bus_if.entry_error, bus_if.load_new_alarm,
                                bus_if.load_new_time}, 32'd0);
    @(posedge clk256);
    #1 reset_n = 1'b1;

    repeat (4) @(posedge clk256);
    check("scoreboard_drained", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
